// File: rtl/riscv_pipe_pkg.sv
// Shared types for the RISC-V inter-stage pipeline registers: stage-register FSM
// states, the MEM/WB payload layout and the packed payload width of each stage.
package riscv_pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL2 = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] WriteData;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] C;
        logic [1:0]  wD_sel;
        logic        RegWrite;
        logic        re1;
        logic        re2;
    } mem_wb_payload_t;

    // Packed widths of each stage boundary; MEM/WB follows the struct above.
    localparam int IF_ID_W  = 96;
    localparam int ID_EX_W  = 200;
    localparam int EX_MEM_W = 168;
    localparam int MEM_WB_W = $bits(mem_wb_payload_t);

endpackage

// File: rtl/pipe_stage_skid_slot.sv
// One pipeline register slot: valid, bubble flag and payload.
// Clear wins over load so a flush always empties the slot.
module pipe_slot #(
    parameter int W           = 128,
    parameter bit ZERO_BUBBLE = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         clear,
    input  logic         bubble_d,
    input  logic [W-1:0] payload_d,
    output logic         valid_q,
    output logic         bubble_q,
    output logic [W-1:0] payload_q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q   <= 1'b0;
            bubble_q  <= 1'b1;
            payload_q <= '0;
        end else if (clear) begin
            valid_q  <= 1'b0;
            bubble_q <= 1'b1;
            if (ZERO_BUBBLE) begin
                payload_q <= '0;
            end
        end else if (load) begin
            valid_q   <= 1'b1;
            bubble_q  <= bubble_d;
            payload_q <= (ZERO_BUBBLE && bubble_d) ? '0 : payload_d;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with optional 2-entry skid buffer, synchronous
// flush and a saturating stall-cycle counter.
module pipe_stage_skid
    import riscv_pipe_pkg::*;
#(
    parameter int PAYLOAD_W   = 128,
    parameter int CNT_W       = 16,
    parameter bit ZERO_BUBBLE = 1'b1,
    parameter bit SKID        = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic                 in_bubble_i,
    input  logic [PAYLOAD_W-1:0] in_payload_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 out_bubble_o,
    output logic [PAYLOAD_W-1:0] out_payload_o,
    input  logic                 stall_clr_i,
    output logic [CNT_W-1:0]     stall_cnt_o,
    output state_t               state_o
);

    // Handshake: a transfer happens on a rising clk edge when valid and ready
    // are both high; valid never waits for ready, and a held entry is stable.

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t state_q, state_d;

    logic accept, send;
    logic main_load, main_clear, main_from_skid;
    logic skid_load, skid_clear;
    logic main_valid, main_bubble;
    logic [PAYLOAD_W-1:0] main_payload;
    logic skid_valid, skid_bubble;
    logic [PAYLOAD_W-1:0] skid_payload;
    logic main_bubble_d;
    logic [PAYLOAD_W-1:0] main_payload_d;

    assign accept = in_valid_i & in_ready_o;
    assign send   = out_valid_o & out_ready_i;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (flush_i) begin
            state_d    = EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d   = ONE;
                        main_load = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && send) begin
                        main_load = 1'b1;
                    end else if (accept && SKID) begin
                        state_d   = FULL2;
                        skid_load = 1'b1;
                    end else if (send) begin
                        state_d    = EMPTY;
                        main_clear = 1'b1;
                    end
                end
                FULL2: begin
                    // Skid entry is always the younger one, so it refills main.
                    if (send && skid_valid) begin
                        state_d        = ONE;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                    end
                end
                default: begin
                    state_d    = EMPTY;
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    assign main_bubble_d  = main_from_skid ? skid_bubble  : in_bubble_i;
    assign main_payload_d = main_from_skid ? skid_payload : in_payload_i;

    pipe_slot #(
        .W           (PAYLOAD_W),
        .ZERO_BUBBLE (ZERO_BUBBLE)
    ) u_main (
        .clk       (clk),
        .reset     (reset),
        .load      (main_load),
        .clear     (main_clear),
        .bubble_d  (main_bubble_d),
        .payload_d (main_payload_d),
        .valid_q   (main_valid),
        .bubble_q  (main_bubble),
        .payload_q (main_payload)
    );

    generate
        if (SKID) begin : g_skid
            logic in_ready_q;

            pipe_slot #(
                .W           (PAYLOAD_W),
                .ZERO_BUBBLE (ZERO_BUBBLE)
            ) u_skid (
                .clk       (clk),
                .reset     (reset),
                .load      (skid_load),
                .clear     (skid_clear),
                .bubble_d  (in_bubble_i),
                .payload_d (in_payload_i),
                .valid_q   (skid_valid),
                .bubble_q  (skid_bubble),
                .payload_q (skid_payload)
            );

            // Registered ready: looks at next state, never at out_ready_i.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    in_ready_q <= 1'b1;
                end else begin
                    in_ready_q <= (state_d != FULL2);
                end
            end

            assign in_ready_o = in_ready_q;
        end else begin : g_no_skid
            assign skid_valid   = 1'b0;
            assign skid_bubble  = 1'b1;
            assign skid_payload = '0;
            assign in_ready_o   = ~main_valid | out_ready_i;
        end
    endgenerate

    assign out_valid_o   = main_valid;
    assign out_bubble_o  = ~main_valid | main_bubble;
    assign out_payload_o = main_payload;
    assign state_o       = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_o <= '0;
        end else if (stall_clr_i) begin
            stall_cnt_o <= '0;
        end else if (out_valid_o && !out_ready_i && (stall_cnt_o != CNT_MAX)) begin
            stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: scenario tasks plus a FIFO scoreboard
// fed on every accepted entry and drained on every sent entry.
module tb_pipe_stage_skid;
    import riscv_pipe_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    logic flush, in_valid, in_bubble, out_ready, stall_clr;
    logic [W-1:0] in_payload;

    logic in_ready, out_valid, out_bubble;
    logic [W-1:0] out_payload;
    logic [3:0] stall_cnt;
    state_t state;

    logic in_ready_nz, out_valid_nz, out_bubble_nz;
    logic [W-1:0] out_payload_nz;
    logic [3:0] stall_cnt_nz;
    state_t state_nz;

    logic [W:0] exp_q[$];
    logic [3:0] exp_stall;
    logic s_in_ready, s_out_valid, s_acc;
    int n_cmp = 0;
    int n_err = 0;
    int n_sent = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(
        .PAYLOAD_W (W), .CNT_W (4), .ZERO_BUBBLE (1'b1), .SKID (1'b1)
    ) u_dut (
        .clk (clk), .reset (reset), .flush_i (flush),
        .in_valid_i (in_valid), .in_ready_o (in_ready),
        .in_bubble_i (in_bubble), .in_payload_i (in_payload),
        .out_valid_o (out_valid), .out_ready_i (out_ready),
        .out_bubble_o (out_bubble), .out_payload_o (out_payload),
        .stall_clr_i (stall_clr), .stall_cnt_o (stall_cnt), .state_o (state)
    );

    pipe_stage_skid #(
        .PAYLOAD_W (W), .CNT_W (4), .ZERO_BUBBLE (1'b0), .SKID (1'b1)
    ) u_dut_nz (
        .clk (clk), .reset (reset), .flush_i (flush),
        .in_valid_i (in_valid), .in_ready_o (in_ready_nz),
        .in_bubble_i (in_bubble), .in_payload_i (in_payload),
        .out_valid_o (out_valid_nz), .out_ready_i (out_ready),
        .out_bubble_o (out_bubble_nz), .out_payload_o (out_payload_nz),
        .stall_clr_i (stall_clr), .stall_cnt_o (stall_cnt_nz), .state_o (state_nz)
    );

    // Called just after a negedge with inputs set; sample, score, advance one clock.
    task automatic cycle();
        logic [W:0] exp;
        logic snd;
        #1;
        s_in_ready  = in_ready;
        s_out_valid = out_valid;
        s_acc       = in_valid & in_ready;
        snd         = out_valid & out_ready;
        n_cmp++;
        if (stall_cnt !== exp_stall) begin
            n_err++;
            $display("FAIL stall_cnt: got %0d expected %0d", stall_cnt, exp_stall);
        end
        if (snd) begin
            n_sent++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output: got bubble=%0b payload=%h expected no entry",
                         out_bubble, out_payload);
            end else begin
                exp = exp_q.pop_front();
                if ({out_bubble, out_payload} !== exp) begin
                    n_err++;
                    $display("FAIL sb_entry: got bubble=%0b payload=%h expected bubble=%0b payload=%h",
                             out_bubble, out_payload, exp[W], exp[W-1:0]);
                end
            end
        end
        if (flush) begin
            exp_q.delete();
        end else if (s_acc) begin
            exp_q.push_back({in_bubble, in_bubble ? {W{1'b0}} : in_payload});
        end
        if (stall_clr) begin
            exp_stall = 4'd0;
        end else if (out_valid && !out_ready && exp_stall != 4'd15) begin
            exp_stall = exp_stall + 4'd1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b1; in_bubble = 1'b0;
        in_payload = 32'hA5A5_A5A5; out_ready = 1'b0; stall_clr = 1'b0;
        exp_stall = 4'd0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || out_bubble !== 1'b1 || in_ready !== 1'b1 ||
            stall_cnt !== 4'd0 || out_payload !== 32'h0 || state !== EMPTY) begin
            n_err++;
            $display("FAIL reset_state: got v=%0b b=%0b r=%0b cnt=%0d p=%h st=%0d expected v=0 b=1 r=1 cnt=0 p=0 st=0",
                     out_valid, out_bubble, in_ready, stall_cnt, out_payload, state);
        end
        reset = 1'b1;
        cycle();
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_bubble !== 1'b0 || out_payload !== 32'hA5A5_A5A5) begin
            n_err++;
            $display("FAIL first_latency: got v=%0b b=%0b p=%h expected v=1 b=0 p=a5a5a5a5",
                     out_valid, out_bubble, out_payload);
        end
        out_ready = 1'b1;
        cycle();
        cycle();
        n_cmp++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_drain: got pending=%0d v=%0b expected pending=0 v=0",
                     exp_q.size(), out_valid);
        end
    endtask

    task automatic test_stream();
        int sent0;
        sent0 = n_sent;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_bubble = 1'b0; in_payload = 32'h100 + i;
            cycle();
            n_cmp++;
            if (s_in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL stream_ready: got %0b expected 1 at entry %0d", s_in_ready, i);
            end
            if (i > 0) begin
                n_cmp++;
                if (s_out_valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL stream_rate: got out_valid=%0b expected 1 at entry %0d", s_out_valid, i);
                end
            end
        end
        in_valid = 1'b0;
        cycle();
        n_cmp++;
        if (n_sent - sent0 != 8 || exp_q.size() != 0 || stall_cnt !== 4'd0) begin
            n_err++;
            $display("FAIL stream_count: got sent=%0d pending=%0d cnt=%0d expected sent=8 pending=0 cnt=0",
                     n_sent - sent0, exp_q.size(), stall_cnt);
        end
    endtask

    task automatic test_fill();
        int n_acc;
        n_acc = 0;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_bubble = 1'b0; in_payload = 32'h200 + k;
            cycle();
            if (s_acc) n_acc++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (n_acc != 2 || in_ready !== 1'b0 || state !== FULL2 || out_payload !== 32'h200) begin
            n_err++;
            $display("FAIL fill_full2: got acc=%0d r=%0b st=%0d p=%h expected acc=2 r=0 st=2 p=00000200",
                     n_acc, in_ready, state, out_payload);
        end
        out_ready = 1'b1;
        cycle();
        cycle();
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL fill_drain: got r=%0b v=%0b pending=%0d expected r=1 v=0 pending=0",
                     in_ready, out_valid, exp_q.size());
        end
    endtask

    task automatic test_flush();
        int sent0;
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_bubble = 1'b0; in_payload = 32'h300 + k;
            cycle();
        end
        flush = 1'b1; in_valid = 1'b1; in_payload = 32'h0000_0BAD;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || out_bubble !== 1'b1 || out_payload !== 32'h0 ||
            in_ready !== 1'b1 || state !== EMPTY) begin
            n_err++;
            $display("FAIL flush_state: got v=%0b b=%0b p=%h r=%0b st=%0d expected v=0 b=1 p=0 r=1 st=0",
                     out_valid, out_bubble, out_payload, in_ready, state);
        end
        sent0 = n_sent;
        out_ready = 1'b1;
        repeat (3) cycle();
        n_cmp++;
        if (n_sent != sent0) begin
            n_err++;
            $display("FAIL flush_dropped: got %0d outputs expected 0", n_sent - sent0);
        end
    endtask

    task automatic test_bubble();
        out_ready = 1'b0;
        in_valid = 1'b1; in_bubble = 1'b1; in_payload = 32'h0000_DEAD;
        cycle();
        in_valid = 1'b0; in_bubble = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_bubble !== 1'b1 || out_payload !== 32'h0) begin
            n_err++;
            $display("FAIL bubble_zero: got v=%0b b=%0b p=%h expected v=1 b=1 p=0",
                     out_valid, out_bubble, out_payload);
        end
        n_cmp++;
        if (out_valid_nz !== 1'b1 || out_bubble_nz !== 1'b1 || out_payload_nz !== 32'h0000_DEAD) begin
            n_err++;
            $display("FAIL bubble_keep: got v=%0b b=%0b p=%h expected v=1 b=1 p=0000dead",
                     out_valid_nz, out_bubble_nz, out_payload_nz);
        end
        out_ready = 1'b1;
        cycle();
        cycle();
    endtask

    task automatic test_stall_sat();
        stall_clr = 1'b1; out_ready = 1'b1;
        cycle();
        stall_clr = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; in_bubble = 1'b0; in_payload = 32'h400;
        cycle();
        in_valid = 1'b0;
        repeat (20) cycle();
        n_cmp++;
        if (stall_cnt !== 4'd15) begin
            n_err++;
            $display("FAIL stall_saturate: got %0d expected 15", stall_cnt);
        end
        stall_clr = 1'b1;
        cycle();
        stall_clr = 1'b0;
        n_cmp++;
        if (stall_cnt !== 4'd0) begin
            n_err++;
            $display("FAIL stall_clear: got %0d expected 0", stall_cnt);
        end
        out_ready = 1'b1;
        cycle();
        cycle();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL final_drain: got %0d pending expected 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_fill();
        test_flush();
        test_bubble();
        test_stall_sat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
